// File: rtl/ncl_seq_pkg.sv
// Shared types and constants for the NCL counter sequencer: FSM state
// encoding and the dual-rail digit codes as seen after synchronisation.
package ncl_seq_pkg;

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_REQ_DATA  = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_WAIT_NULL = 3'd4,
        S_HALT      = 3'd5
    } seq_state_e;

    // Digit code is {rail1, rail0}
    localparam logic [1:0] RAIL_NULL = 2'b00;
    localparam logic [1:0] RAIL_D0   = 2'b01;
    localparam logic [1:0] RAIL_D1   = 2'b10;
    localparam logic [1:0] RAIL_ILL  = 2'b11;

endpackage

// File: rtl/ncl_dr_sync.sv
// Brings the clockless dual-rail count into the clock domain through a
// flop chain on every rail, then decodes per-digit completeness.
// Decode is combinational from the last sync stage so a rail change is
// visible SYNC_STAGES cycles after it arrives.
module ncl_dr_sync
    import ncl_seq_pkg::*;
#(
    parameter int DIGITS      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  init_n,
    input  logic [2*DIGITS-1:0]   rails_in,
    output logic                  all_data,
    output logic                  all_null,
    output logic                  illegal,
    output logic [DIGITS-1:0]     value
);

    // Stage 0 takes the raw rails; stage SYNC_STAGES-1 feeds the decode.
    logic [SYNC_STAGES-1:0][2*DIGITS-1:0] sync_q;

    logic [DIGITS-1:0] is_null;
    logic [DIGITS-1:0] is_data;
    logic [DIGITS-1:0] is_ill;

    // Shift every rail through the synchroniser chain.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rails_in};
        end
    end

    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [1:0] code;
        assign code        = sync_q[SYNC_STAGES-1][2*gi +: 2];
        assign is_null[gi] = (code == RAIL_NULL);
        assign is_data[gi] = (code == RAIL_D0) || (code == RAIL_D1);
        assign is_ill[gi]  = (code == RAIL_ILL);
        assign value[gi]   = code[1];
    end

    assign all_data = &is_data;
    assign all_null = &is_null;
    assign illegal  = |is_ill;

endmodule

// File: rtl/ncl_counter_seq.sv
// Clocked sequencer for the dual-rail NCL counter: issues init, alternates
// DATA/NULL requests on ncl_comp, captures each complete DATA wavefront
// and offers it over valid/ready. Define NCL_SEQ_TIMEOUT_EN to add a
// wavefront watchdog that halts the sequencer after TIMEOUT cycles
// waiting in WAIT_DATA or WAIT_NULL.
module ncl_counter_seq
    import ncl_seq_pkg::*;
#(
    parameter int DIGITS      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int INIT_CYCLES = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  init_n,
    output logic                  ncl_init,
    output logic [DIGITS-1:0]     ncl_comp,
    input  logic [2*DIGITS-1:0]   ncl_count,
    input  logic                  run,
    input  logic                  step,
    input  logic                  stop_en,
    input  logic [DIGITS-1:0]     target,
    output logic [DIGITS-1:0]     cnt_value,
    output logic                  cnt_valid,
    input  logic                  cnt_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    logic              all_data;
    logic              all_null;
    logic              illegal;
    logic [DIGITS-1:0] sync_value;

    ncl_dr_sync #(
        .DIGITS      (DIGITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .init_n   (init_n),
        .rails_in (ncl_count),
        .all_data (all_data),
        .all_null (all_null),
        .illegal  (illegal),
        .value    (sync_value)
    );

    seq_state_e        state_q,     state_d;
    logic [INIT_W-1:0] init_cnt_q,  init_cnt_d;
    logic              ncl_init_q,  ncl_init_d;
    logic              comp_q,      comp_d;
    logic [DIGITS-1:0] cnt_value_q, cnt_value_d;
    logic              cnt_valid_q, cnt_valid_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;

    // Consumer takes the held value at the coming edge.
    logic accept;
    assign accept = cnt_valid_q && cnt_ready;

`ifdef NCL_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // Next-state and output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ncl_init_d  = 1'b0;
        comp_d      = comp_q;
        cnt_value_d = cnt_value_q;
        cnt_valid_d = cnt_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (accept) begin
            cnt_valid_d = 1'b0;
        end

        unique case (state_q)
            S_INIT: begin
                comp_d = 1'b0;
                if (init_cnt_q < INIT_W'(INIT_CYCLES)) begin
                    ncl_init_d = 1'b1;
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end else if (all_null) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (run || step) begin
                    state_d = S_REQ_DATA;
                end
            end
            S_REQ_DATA: begin
                comp_d  = 1'b1;
                state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (all_data) begin
                    cnt_value_d = sync_value;
                    cnt_valid_d = 1'b1;
                    comp_d      = 1'b0;
                    state_d     = S_WAIT_NULL;
                end
            end
            S_WAIT_NULL: begin
                // The NULL phase overlaps the output hold; leave only once
                // both are finished so no request races a pending value.
                if (all_null && (!cnt_valid_q || cnt_ready)) begin
                    if (stop_en && (cnt_value_q == target)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (run) begin
                        state_d = S_REQ_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                comp_d = 1'b0;
            end
            default: begin
                comp_d  = 1'b0;
                state_d = S_HALT;
            end
        endcase

`ifdef NCL_SEQ_TIMEOUT_EN
        if (((state_q == S_WAIT_DATA) || (state_q == S_WAIT_NULL)) &&
            (state_d == state_q) && (wd_cnt_q == WD_W'(TIMEOUT - 1))) begin
            err_d   = 1'b1;
            comp_d  = 1'b0;
            state_d = S_HALT;
        end
`endif

        // An 11 code means the datapath is broken; stop driving it.
        if (illegal && (state_q != S_HALT)) begin
            err_d       = 1'b1;
            comp_d      = 1'b0;
            ncl_init_d  = 1'b0;
            done_d      = 1'b0;
            cnt_value_d = cnt_value_q;
            state_d     = S_HALT;
        end

        busy_d = (state_d != S_IDLE);
    end

`ifdef NCL_SEQ_TIMEOUT_EN
    // Watchdog counts cycles spent in a wait state, restarting on entry.
    always_comb begin
        wd_cnt_d = '0;
        if (((state_q == S_WAIT_DATA) || (state_q == S_WAIT_NULL)) &&
            (state_d == state_q)) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            ncl_init_q  <= 1'b0;
            comp_q      <= 1'b0;
            cnt_value_q <= '0;
            cnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ncl_init_q  <= ncl_init_d;
            comp_q      <= comp_d;
            cnt_value_q <= cnt_value_d;
            cnt_valid_q <= cnt_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ncl_init  = ncl_init_q;
    assign ncl_comp  = {DIGITS{comp_q}};
    assign cnt_value = cnt_value_q;
    assign cnt_valid = cnt_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ncl_counter_seq.sv
// Bench for ncl_counter_seq: a behavioural dual-rail counter answers the
// completion requests, a scoreboard holds every value the counter put on
// the rails, and one compare process checks delivery and handshake rules
// every cycle. Directed scenarios add hand-computed literal expectations.
module tb_ncl_counter_seq;

    localparam int D  = 32;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            init_n = 1'b0;
    logic            ncl_init;
    logic [D-1:0]    ncl_comp;
    logic [2*D-1:0]  rails = '0;
    logic            run = 1'b0;
    logic            step = 1'b0;
    logic            stop_en = 1'b0;
    logic [D-1:0]    target = '0;
    logic [D-1:0]    cnt_value;
    logic            cnt_valid;
    logic            cnt_ready = 1'b0;
    logic            busy;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    ncl_counter_seq #(
        .DIGITS      (D),
        .SYNC_STAGES (2),
        .INIT_CYCLES (4),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .init_n    (init_n),
        .ncl_init  (ncl_init),
        .ncl_comp  (ncl_comp),
        .ncl_count (rails),
        .run       (run),
        .step      (step),
        .stop_en   (stop_en),
        .target    (target),
        .cnt_value (cnt_value),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural counter model ----------------
    logic [31:0] cval  = '0;
    int          mode  = 0;    // 0 normal, 1 digit 7 illegal, 2 never completes
    bit          shown = 1'b0;
    bit          phase = 1'b0;
    logic [31:0] sb[$];
    logic [31:0] acc_log[$];
    int          done_cnt = 0;

    function automatic logic [63:0] full_rails(input logic [31:0] v);
        logic [63:0] r;
        for (int i = 0; i < 32; i++) begin
            r[2*i]   = ~v[i];
            r[2*i+1] = v[i];
        end
        return r;
    endfunction

    // One cycle of partial wavefront (low 16 digits DATA) precedes full DATA.
    always @(negedge clk) begin
        if (ncl_init) begin
            rails = '0;
            phase = 1'b0;
        end else if (ncl_comp[0]) begin
            case (mode)
                0: begin
                    if (!shown) begin
                        if (!phase) begin
                            rails = full_rails(cval) & 64'h0000_0000_FFFF_FFFF;
                            phase = 1'b1;
                        end else begin
                            rails = full_rails(cval);
                            shown = 1'b1;
                            sb.push_back(cval);
                        end
                    end
                end
                1: begin
                    rails = full_rails(cval);
                    rails[15:14] = 2'b11;
                end
                default: rails = full_rails(cval) & 64'h0000_0000_FFFF_FFFF;
            endcase
        end else begin
            if (shown) begin
                cval  = cval + 32'd1;
                shown = 1'b0;
            end
            rails = '0;
            phase = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_done  = 1'b0;
    logic [31:0] prev_value = '0;

    always @(negedge clk) begin
        if (init_n) begin
            chk("comp_uniform", ((&ncl_comp) || (~|ncl_comp)), 1);
            if (ncl_comp[0]) chk("no_req_while_holding", cnt_valid, 0);
            if (err) chk("halt_comp_low", ncl_comp[0], 0);
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", cnt_valid, 1);
                chk("hold_stable", cnt_value, prev_value);
            end
            if (cnt_valid && cnt_ready) begin
                chk("sb_pending", (sb.size() != 0), 1);
                if (sb.size() != 0) chk("sb_value", cnt_value, sb.pop_front());
                acc_log.push_back(cnt_value);
            end
            if (done) begin
                done_cnt++;
                chk("done_in_idle", busy, 0);
            end
            if (prev_done) chk("done_one_cycle", done, 0);
            prev_valid = cnt_valid;
            prev_ready = cnt_ready;
            prev_done  = done;
            prev_value = cnt_value;
        end else begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_done  = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_for(input int sel, input int max_c, input string name);
        int  n = 0;
        bit  hit = 1'b0;
        while (n < max_c && !hit) begin
            @(negedge clk);
            case (sel)
                0:       hit = !busy;
                1:       hit = cnt_valid;
                2:       hit = ncl_comp[0];
                3:       hit = err;
                default: hit = done;
            endcase
            n++;
        end
        chk({name, "_reached"}, hit, 1);
    endtask

    task automatic pulse_step();
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ncl_init"},  ncl_init, 0);
        chk({name, "_ncl_comp"},  ncl_comp, 0);
        chk({name, "_cnt_value"}, cnt_value, 0);
        chk({name, "_cnt_valid"}, cnt_valid, 0);
        chk({name, "_busy"},      busy, 0);
        chk({name, "_done"},      done, 0);
        chk({name, "_err"},       err, 0);
    endtask

    // Release reset, expect a 4-cycle init pulse, then IDLE.
    task automatic release_and_init(input string name);
        int hi = 0;
        @(negedge clk);
        init_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ncl_init) hi++;
        end
        chk({name, "_init_len"}, hi, 4);
        wait_for(0, 20, {name, "_idle"});
    endtask

    // Assert reset asynchronously mid-cycle, check outputs clear at once.
    task automatic async_reset(input string name);
        @(posedge clk); #3;
        init_n = 1'b0;
        #1;
        check_all_zero(name);
        sb.delete();
        mode  = 0;
        shown = 1'b0;
        release_and_init(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int dbase;
        int hold;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        release_and_init("startup");
        chk("startup_comp", ncl_comp[0], 0);

        // Single step, value 1, consumer slow
        @(posedge clk); #1;
        cval = 32'h1;
        cnt_ready = 1'b0;
        pulse_step();
        wait_for(1, 50, "step_valid");
        chk("step_value", cnt_value, 32'h0000_0001);
        chk("step_valid_hi", cnt_valid, 1);
        chk("step_comp_low", ncl_comp, 0);
        @(posedge clk); #1;
        cnt_ready = 1'b1;
        @(posedge clk); #1;
        cnt_ready = 1'b0;
        wait_for(0, 50, "step_idle");
        chk("step_sb_empty", sb.size(), 0);

        // Run with consumer stalled for 20 cycles
        @(posedge clk); #1;
        cval = 32'd10;
        run  = 1'b1;
        wait_for(1, 50, "hold_first");
        @(posedge clk); #1;
        hold = 0;
        repeat (20) begin
            @(negedge clk);
            if (cnt_valid && !ncl_comp[0]) hold++;
        end
        chk("hold_cycles", hold, 20);
        chk("hold_one_value", sb.size(), 1);
        chk("hold_value", cnt_value, 32'd10);
        @(posedge clk); #1;
        cnt_ready = 1'b1;
        wait_for(2, 30, "hold_next_req");
        run = 1'b0;
        wait_for(0, 60, "hold_idle");
        chk("hold_sb_empty", sb.size(), 0);

        // Stop at target 5 from 0
        @(posedge clk); #1;
        cval    = 32'd0;
        stop_en = 1'b1;
        target  = 32'd5;
        base    = acc_log.size();
        dbase   = done_cnt;
        run     = 1'b1;
        wait_for(4, 600, "stop_done");
        run = 1'b0;
        repeat (4) @(negedge clk);
        chk("stop_count", acc_log.size() - base, 6);
        if (acc_log.size() >= base + 6) begin
            chk("stop_first", acc_log[base], 32'd0);
            chk("stop_last", acc_log[base+5], 32'd5);
        end
        chk("stop_done_once", done_cnt - dbase, 1);
        chk("stop_busy", busy, 0);
        @(posedge clk); #1;
        stop_en = 1'b0;

        // Wrap-around
        cval = 32'hFFFF_FFFE;
        base = acc_log.size();
        run  = 1'b1;
        n = 0;
        while ((acc_log.size() - base) < 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        chk("wrap_reached", ((acc_log.size() - base) >= 3), 1);
        wait_for(0, 60, "wrap_idle");
        if (acc_log.size() >= base + 3) begin
            chk("wrap_v0", acc_log[base],   32'hFFFF_FFFE);
            chk("wrap_v1", acc_log[base+1], 32'hFFFF_FFFF);
            chk("wrap_v2", acc_log[base+2], 32'h0000_0000);
        end
        chk("wrap_no_err", err, 0);
        chk("wrap_sb_empty", sb.size(), 0);

        // Illegal code on digit 7
        @(posedge clk); #1;
        mode = 1;
        pulse_step();
        wait_for(3, 50, "illegal_err");
        chk("illegal_halt_busy", busy, 1);
        pulse_step();
        hold = 0;
        repeat (10) begin
            @(negedge clk);
            if (ncl_comp[0]) hold++;
        end
        chk("illegal_comp_low", hold, 0);
        chk("illegal_err_sticky", err, 1);
        chk("illegal_no_valid", cnt_valid, 0);
        async_reset("illegal_recover");

`ifdef NCL_SEQ_TIMEOUT_EN
        // Watchdog: DATA never completes
        @(posedge clk); #1;
        mode = 2;
        pulse_step();
        wait_for(2, 20, "wd_req");
        n = 0;
        while (!err && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        chk("wd_latency", n, TO);
        chk("wd_halt_comp", ncl_comp[0], 0);
        async_reset("wd_recover");
`endif

        // Reset pulsed during WAIT_DATA
        @(posedge clk); #1;
        mode = 2;
        pulse_step();
        wait_for(2, 20, "midwait_req");
        repeat (5) @(negedge clk);
`ifndef NCL_SEQ_TIMEOUT_EN
        repeat (100) @(negedge clk);
        chk("no_watchdog_err", err, 0);
`endif
        chk("midwait_busy", busy, 1);
        chk("midwait_comp", ncl_comp[0], 1);
        async_reset("midwait");

        // Normal operation after restart
        @(posedge clk); #1;
        cval = 32'h0000_1234;
        pulse_step();
        wait_for(1, 50, "restart_valid");
        chk("restart_value", cnt_value, 32'h0000_1234);
        wait_for(0, 50, "restart_idle");
        chk("restart_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/ncl_counter_seq.md
# ncl_counter_seq

Clocked sequencer for the 32-digit dual-rail NCL counter. It generates the counter's `init` pulse and drives the per-digit completion inputs to alternate DATA and NULL wavefronts. It synchronises the dual-rail count back into the clock domain, checks completeness, and hands each completed value to a synchronous consumer over a valid/ready handshake. It sits at the boundary between the clockless counter datapath and the clocked system logic.

## Interface
- `DIGITS`, 32: number of dual-rail digits in the counter.
- `SYNC_STAGES`, 2: flop stages on every incoming rail (minimum 2).
- `INIT_CYCLES`, 4: cycles `ncl_init` is held high.
- `TIMEOUT`, 1024: wavefront watchdog limit in cycles; used only with `NCL_SEQ_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `init_n`  in  1  asynchronous active-low reset.
- `ncl_init`  out  1  init to the counter, active high.
- `ncl_comp`  out  DIGITS  completion to the counter. All bits are equal. 1 requests DATA; 0 requests NULL.
- `ncl_count`  in  2*DIGITS  dual-rail count. Bit 2i is rail0 of digit i; bit 2i+1 is rail1.
- `run`  in  1  level. While high, request wavefronts continuously.
- `step`  in  1  pulse. In IDLE, request exactly one wavefront.
- `stop_en`  in  1  enables stop-at-target.
- `target`  in  DIGITS  stop value.
- `cnt_value`  out  DIGITS  captured binary count (rail1 of each digit).
- `cnt_valid`  out  1  `cnt_value` is held until it is accepted.
- `cnt_ready`  in  1  consumer accept.
- `busy`  out  1  the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when the target is reached.
- `err`  out  1  sticky error. Cleared only by `init_n`.

## Operation
- Digit decode (after sync):
  - 00 is NULL.
  - 01 is DATA 0.
  - 10 is DATA 1.
  - 11 is illegal. An illegal code sets `err` and forces the FSM to HALT.
- `all_data`: every digit is DATA. `all_null`: every digit is NULL.
- Reset values: all outputs 0; the FSM is in INIT.
- FSM states and transitions:
  - INIT: `ncl_init`=1 and `ncl_comp`=0 for INIT_CYCLES. Then wait for `all_null` and go to IDLE.
  - IDLE: go to REQ_DATA when `run`=1 or `step`=1. `step` has the same effect as `run` for one wavefront.
  - REQ_DATA: set `ncl_comp`=all 1, then WAIT_DATA.
  - WAIT_DATA: on `all_data`, capture `cnt_value`, assert `cnt_valid`, set `ncl_comp`=0, then WAIT_NULL.
  - WAIT_NULL: on `all_null` and with no valid pending (`cnt_valid`=0, or `cnt_ready`=1 this cycle):
    - If `stop_en` and the captured value equals `target`, pulse `done` and go to IDLE.
    - Else, if `run`=1, go to REQ_DATA.
    - Else go to IDLE.
  - HALT: all ack outputs stay 0; only `init_n` exits.
- Partial wavefronts (some DATA, some NULL) are waited on and never captured.
- The NULL phase overlaps the output hold. A new DATA request is never issued while `cnt_valid`=1 and `cnt_ready`=0.
- Wrap-around: 0xFFFFFFFF is followed by 0x00000000. This is not an error.
- Dropping `run` mid-wavefront: the current wavefront completes (DATA, capture, NULL), then the FSM goes to IDLE.
- `step` outside IDLE is ignored.

## Timing
- A rail change is visible to decode SYNC_STAGES cycles after it arrives.
- `cnt_valid` rises 1 cycle after `all_data` is decoded.
- `ncl_comp` falls in the same cycle that `cnt_valid` rises.
- `cnt_valid` falls in the cycle after `cnt_ready`=1 while `cnt_valid`=1.
- `ncl_comp` rises at the earliest 1 cycle after WAIT_NULL exits.
- Per-value throughput is bounded below by 2*(SYNC_STAGES+2) cycles plus the counter's wavefront delay.
- `done` is high for exactly 1 cycle, in the IDLE entry cycle.
- `init_n` low asynchronously forces all outputs to 0 and the FSM to INIT.

## Configuration
- `NCL_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DATA and WAIT_NULL.
  - It reloads on every state entry.
  - Reaching TIMEOUT sets `err` and moves the FSM to HALT.
- Not defined: no watchdog. The FSM waits indefinitely, and `err` is set only by illegal codes.

## Structure
- Package `ncl_seq_pkg`:
  - FSM state enum (INIT, IDLE, REQ_DATA, WAIT_DATA, WAIT_NULL, HALT).
  - Rail code constants: NULL=2'b00, D0=2'b01, D1=2'b10.
- Sub-module `ncl_dr_sync`:
  - SYNC_STAGES flop chain per rail.
  - Produces `all_data`, `all_null`, `illegal` and the binary value.
- The FSM, ack register, capture register and (optional) watchdog live in the top module.

## Test plan
- Reset, then release `init_n`:
  - All outputs are 0 during reset.
  - After release, `ncl_init`=1 for exactly 4 cycles.
  - The FSM enters IDLE once the model drives all NULL.
- `step` with the model returning 0x00000001: `cnt_value`=0x00000001, `cnt_valid`=1, `ncl_comp`=0; after NULL the FSM returns to IDLE.
- `run`=1 with `cnt_ready` held low for 20 cycles: exactly one value is held, and `ncl_comp` stays 0 until the accept.
- `run`=1, `stop_en`=1, `target`=5, model counting from 0: values 0..5 are delivered, `done` pulses once, `busy`=0.
- Model drives 11 on digit 7: `err`=1, the FSM goes to HALT, `ncl_comp` stays 0.
- Model starting at 0xFFFFFFFE: delivers 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 with no error.
- `init_n` pulsed low during WAIT_DATA: outputs clear immediately and the FSM restarts in INIT.
- With `NCL_SEQ_TIMEOUT_EN`, model never completes DATA: `err` rises exactly at TIMEOUT cycles after WAIT_DATA entry.
